hex_display_scheduler: RTL and testbench

Time-multiplexed display controller that shares one hex-to-7-segment decoder across `NUM_DIGITS` common-select digits. It scans the digits in rotation and blanks a guard cycle between them to suppress ghosting. A new display word is accepted through a Load/Ack handshake and applied only at a frame boundary, so the display never tears. It sits between the processor's register/result outputs and the board's multiplexed seven-segment pins.

---
 rtl/display_pkg.sv | 9 +
 rtl/hex_seg_decoder.sv | 33 +++
 rtl/hex_display_scheduler.sv | 112 +++++++++++
 tb/tb_hex_display_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the seven-segment display path
package display_pkg;

  typedef logic [0:6] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_seg_decoder.sv
// rtl/hex_seg_decoder.sv - combinational hex nibble to active-low segments a..g
module hex_seg_decoder
  import display_pkg::*;
(
  input  nibble_t nibble_i,
  output seg_t    seg_o
);

  // Bit 0 of seg_t is segment a; 0 lights a segment.
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - multiplexed hex display scan with guard slots and frame-synchronous word update
module hex_display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    Clk,
  input  logic                    ResetN,
  input  logic                    En,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  output logic                    Busy,
  output logic                    Ack,
  output logic [NUM_DIGITS-1:0]   DigitSel,
  output seg_t                    Seg
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [W-1:0]          staging_q, staging_d;
  logic [W-1:0]          shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  ack_q, ack_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  seg_t                  seg_q, seg_d;

  logic                  terminal;
  logic                  frame_end;
  logic [W-1:0]          upper;
  nibble_t               cur_nibble;
  seg_t                  dec_seg;

  assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];

  hex_seg_decoder u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    staging_d   = staging_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    ack_d       = 1'b0;
    digit_sel_d = '1;
    terminal    = En && (cnt_q == CNT_LAST);
    frame_end   = terminal && (idx_q == IDX_LAST);
    upper       = shadow_q >> {idx_q, 2'b00};

    if (En) begin
      cnt_d = terminal ? '0 : cnt_q + 1'b1;
      if (terminal) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end

    // Transfer keys off the old pending flag, so a word accepted on the
    // frame-end cycle itself waits for the following frame end.
    if (frame_end && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
    if (Load && !pending_q) begin
      staging_d = Value;
      pending_d = 1'b1;
    end

    if (En && (cnt_q != '0)) begin
      digit_sel_d[idx_q] = 1'b0;
    end
    seg_d = (BLANK_LEADING && (idx_q != '0) && (upper == '0)) ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      staging_q   <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      digit_sel_q <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign Busy     = pending_q;
  assign Ack      = ack_q;
  assign DigitSel = digit_sel_q;
  assign Seg      = seg_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb/tb_hex_display_scheduler.sv - directed self-checking bench for hex_display_scheduler
module tb_hex_display_scheduler;
  import display_pkg::*;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        En;
  logic [15:0] Value;
  logic        Load;
  logic        Busy;
  logic        Ack;
  logic [3:0]  DigitSel;
  seg_t        Seg;

  int n_checks = 0;
  int n_err    = 0;
  int pos      = 0;

  localparam logic [6:0] BL = 7'b1111111;

  hex_display_scheduler #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .BLANK_LEADING (1'b1)
  ) dut (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .En       (En),
    .Value    (Value),
    .Load     (Load),
    .Busy     (Busy),
    .Ack      (Ack),
    .DigitSel (DigitSel),
    .Seg      (Seg)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pos is the bench's own scan position (cnt + 4*idx) after each edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (ResetN && En) pos = (pos + 1) % 16;
  endtask

  task automatic frame_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] segs [4];
    logic [3:0] esel;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int j = 0; j < 16; j++) begin
      tick();
      esel = ((j % 4) == 0) ? 4'hF : (4'hF & ~(4'h1 << (j / 4)));
      chk($sformatf("%s_sel%0d", tag, j), 32'(DigitSel), 32'(esel));
      chk($sformatf("%s_seg%0d", tag, j), 32'(Seg), 32'(segs[j / 4]));
      chk($sformatf("%s_ack%0d", tag, j), 32'(Ack), 32'd0);
    end
  endtask

  task automatic run_to_ack(input string tag, input int exp_ticks);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!Ack && n < 40);
    chk({tag, "_ack_latency"}, 32'(n), 32'(exp_ticks));
    chk({tag, "_ack"}, 32'(Ack), 32'd1);
    chk({tag, "_busy_fall"}, 32'(Busy), 32'd0);
  endtask

  task automatic load_show(input string tag, input logic [15:0] v, input logic [6:0] s0,
                           input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    Load = 1'b1; Value = v;
    tick();
    Load = 1'b0;
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    run_to_ack(tag, 15);
    frame_check(tag, s0, s1, s2, s3);
  endtask

  initial begin
    ResetN = 1'b0; En = 1'b1; Load = 1'b0; Value = '0;
    tick(); tick();
    chk("rst_sel", 32'(DigitSel), 32'hF);
    chk("rst_seg", 32'(Seg), 32'(BL));
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    ResetN = 1'b1; pos = 0;
    frame_check("post_rst", 7'b0000001, BL, BL, BL);

    load_show("w12AF", 16'h12AF, 7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111);
    load_show("w0005", 16'h0005, 7'b0100100, BL, BL, BL);

    repeat (15) tick();
    Load = 1'b1; Value = 16'h0000;
    tick();
    Load = 1'b0;
    chk("fe_load_pos", 32'(pos), 32'd0);
    chk("fe_load_noack", 32'(Ack), 32'd0);
    chk("fe_load_busy", 32'(Busy), 32'd1);
    run_to_ack("w0000", 16);
    frame_check("w0000", 7'b0000001, BL, BL, BL);

    Load = 1'b1; Value = 16'h1234;
    tick();
    chk("rej_busy1", 32'(Busy), 32'd1);
    Value = 16'hBEEF;
    tick();
    Load = 1'b0;
    chk("rej_busy2", 32'(Busy), 32'd1);
    run_to_ack("w1234", 14);
    frame_check("w1234a", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);
    chk("rej_idle", 32'(Busy), 32'd0);
    frame_check("w1234b", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);

    load_show("wCDE6", 16'hCDE6, 7'b0100000, 7'b0110000, 7'b1000010, 7'b0110001);
    load_show("w8B97", 16'h8B97, 7'b0001111, 7'b0000100, 7'b1100000, 7'b0000000);

    repeat (10) tick();
    chk("dis_pos", 32'(pos), 32'd10);
    En = 1'b0; Load = 1'b1; Value = 16'h0042;
    tick();
    Load = 1'b0;
    chk("dis_sel0", 32'(DigitSel), 32'hF);
    chk("dis_busy", 32'(Busy), 32'd1);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk($sformatf("dis_sel%0d", k), 32'(DigitSel), 32'hF);
      chk($sformatf("dis_ack%0d", k), 32'(Ack), 32'd0);
    end
    En = 1'b1;
    tick();
    chk("resume_sel", 32'(DigitSel), 32'hB);
    run_to_ack("w0042", 5);
    frame_check("w0042", 7'b0010010, 7'b1001100, BL, BL);

    Load = 1'b1; Value = 16'h5678;
    tick();
    Load = 1'b0;
    repeat (4) tick();
    chk("mid_busy", 32'(Busy), 32'd1);
    ResetN = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_ack", 32'(Ack), 32'd0);
    chk("mid_rst_sel", 32'(DigitSel), 32'hF);
    chk("mid_rst_seg", 32'(Seg), 32'(BL));
    ResetN = 1'b1; pos = 0;
    frame_check("mid_rst_f1", 7'b0000001, BL, BL, BL);
    chk("mid_rst_busy2", 32'(Busy), 32'd0);
    frame_check("mid_rst_f2", 7'b0000001, BL, BL, BL);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
